// File: rtl/fxp_conv_pkg.sv
// Shared definitions for the fixed-point circular convolution block.
//   QLEN_DEF / FRAC_SIZE_DEF : default word width and fractional bits (Q4.12)
//   state_t                  : sequencer states IDLE / MAC / OUT
//   sat_fxp                  : clamp a wide signed value to a qlen-bit signed range
package fxp_conv_pkg;

  localparam int unsigned QLEN_DEF      = 16;
  localparam int unsigned FRAC_SIZE_DEF = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  // Result is 64 bits wide; callers size-cast it down to their word width.
  function automatic logic signed [63:0] sat_fxp(input logic signed [63:0] v,
                                                 input int unsigned       qlen);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (qlen - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/fxp_mult.sv
// Signed fixed-point multiplier (combinational).
//   i_a, i_b : QLEN-bit signed operands with FRAC_SIZE fractional bits
//   o_p      : product in the same format, floor-rounded and saturated
import fxp_conv_pkg::*;

module fxp_mult #(
  parameter int unsigned QLEN      = QLEN_DEF,
  parameter int unsigned FRAC_SIZE = FRAC_SIZE_DEF
) (
  input  logic [QLEN-1:0] i_a,
  input  logic [QLEN-1:0] i_b,
  output logic [QLEN-1:0] o_p
);

  logic signed [2*QLEN-1:0] w_full;
  logic signed [2*QLEN-1:0] w_shift;
  logic signed [63:0]       w_ext;

  assign w_full  = $signed(i_a) * $signed(i_b);
  assign w_shift = w_full >>> FRAC_SIZE;
  assign w_ext   = {{(64-2*QLEN){w_shift[2*QLEN-1]}}, w_shift};

  always_comb o_p = QLEN'(sat_fxp(w_ext, QLEN));

endmodule

// File: rtl/fxp_circconv_seq.sv
// Sequential N-point circular convolution y[k] = sum_j x[j]*h[(k-j) mod N].
// One shared multiplier, one product per cycle; outputs leave in ascending k
// through a valid/ready handshake.
//   clk, rst        : clock, asynchronous active-high reset
//   wr_x, wr_h      : load wr_data into x[wr_addr] / h[wr_addr] (IDLE only, x wins)
//   wr_addr, wr_data: sample index and signed fixed-point sample
//   start           : begin a pass (IDLE only, ignored when a write coincides)
//   busy            : high while not IDLE
//   out_valid/ready : output handshake; out_data = sat(y[out_idx])
//   done            : one-cycle pulse after the final (k = N-1) transfer
import fxp_conv_pkg::*;

module fxp_circconv_seq #(
  parameter int unsigned QLEN      = QLEN_DEF,
  parameter int unsigned FRAC_SIZE = FRAC_SIZE_DEF,
  parameter int unsigned N         = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_x,
  input  logic                 wr_h,
  input  logic [$clog2(N)-1:0] wr_addr,
  input  logic [QLEN-1:0]      wr_data,
  input  logic                 start,
  output logic                 busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [QLEN-1:0]      out_data,
  output logic [$clog2(N)-1:0] out_idx,
  output logic                 done
);

  localparam int unsigned L  = $clog2(N);
  localparam int unsigned AW = QLEN + L;
  localparam logic [L-1:0] LAST = L'(N - 1);

  state_t r_state;
  state_t w_next;

  logic [QLEN-1:0]      r_x [N];
  logic [QLEN-1:0]      r_h [N];
  logic [L-1:0]         r_k;
  logic [L-1:0]         r_j;
  logic signed [AW-1:0] r_acc;
  logic [QLEN-1:0]      r_out_data;
  logic [L-1:0]         r_out_idx;
  logic                 r_done;

  logic                 w_write;
  logic                 w_start;
  logic [L-1:0]         w_hidx;
  logic [QLEN-1:0]      w_prod;
  logic signed [AW-1:0] w_sum;
  logic signed [63:0]   w_sum_ext;

  assign w_write = wr_x | wr_h;
  assign w_start = start & ~w_write;
  // Truncating the difference to L bits is the modulo-N wrap.
  assign w_hidx  = r_k - r_j;

  fxp_mult #(
    .QLEN      (QLEN),
    .FRAC_SIZE (FRAC_SIZE)
  ) u_mult (
    .i_a (r_x[r_j]),
    .i_b (r_h[w_hidx]),
    .o_p (w_prod)
  );

  assign w_sum     = r_acc + {{L{w_prod[QLEN-1]}}, w_prod};
  assign w_sum_ext = {{(64-AW){w_sum[AW-1]}}, w_sum};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_next = MAC;
      MAC:     if (r_j == LAST) w_next = OUT;
      OUT:     if (out_ready) w_next = (r_k == LAST) ? IDLE : MAC;
      default: w_next = IDLE;
    endcase
  end

  // Sample storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (r_state == IDLE) begin
      if (wr_x)      r_x[wr_addr] <= wr_data;
      else if (wr_h) r_h[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_k        <= '0;
      r_j        <= '0;
      r_acc      <= '0;
      r_out_data <= '0;
      r_out_idx  <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_k   <= '0;
            r_j   <= '0;
            r_acc <= '0;
          end
        end
        MAC: begin
          if (r_j == LAST) begin
            r_out_data <= QLEN'(sat_fxp(w_sum_ext, QLEN));
            r_out_idx  <= r_k;
          end else begin
            r_acc <= w_sum;
            r_j   <= r_j + L'(1);
          end
        end
        OUT: begin
          if (out_ready) begin
            if (r_k == LAST) begin
              r_done <= 1'b1;
            end else begin
              r_k   <= r_k + L'(1);
              r_j   <= '0;
              r_acc <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (r_state != IDLE);
  assign out_valid = (r_state == OUT);
  assign out_data  = r_out_data;
  assign out_idx   = r_out_idx;
  assign done      = r_done;

endmodule
